// File: rtl/wash_sequencer.sv
`timescale 1ns/1ps
// Wash-program sequencer: full, rinse+spin and spin-only programs with pause and door interlock.
// Optional completion buzzer is built when WASHER_BUZZER_EN is defined; otherwise buzzer is tied 0.
module wash_sequencer #(
  parameter int CLK_PER_TICK = 50_000_000,
  parameter int TIME_W       = 8,
  parameter int NUM_RINSE    = 2,
  parameter int T_FILL       = 10,
  parameter int T_WASH       = 30,
  parameter int T_RINSE      = 20,
  parameter int T_DRAIN      = 10,
  parameter int T_SPIN       = 15,
  parameter int BUZZ_TICKS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              door_open,
  input  logic [1:0]        mode,
  output logic [2:0]        phase,
  output logic [2:0]        rinse_cnt,
  output logic [TIME_W-1:0] phase_left,
  output logic              busy,
  output logic              paused,
  output logic              done_pulse,
  output logic              buzzer
);
  localparam int DIV_W = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_PER_TICK - 1);

  localparam logic [1:0] PROG_FULL  = 2'd0;
  localparam logic [1:0] PROG_RINSE = 2'd1;
  localparam logic [1:0] PROG_SPIN  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WASH  = 3'd2,
    S_RINSE = 3'd3,
    S_DRAIN = 3'd4,
    S_SPIN  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t           state;
  state_t           nxt_state;
  logic [1:0]       prog;
  logic             in_rinse;
  logic             nxt_in_rinse;
  logic             rinse_inc;
  logic [2:0]       rinse_goal;
  logic [DIV_W-1:0] div_cnt;
  logic             running;
  logic             div_run;
  logic             buzz_run;
  logic             tick;
  logic             phase_end;
  logic             start_ok;

  function automatic logic [TIME_W-1:0] phase_len(input state_t s);
    case (s)
      S_FILL:  phase_len = TIME_W'(T_FILL);
      S_WASH:  phase_len = TIME_W'(T_WASH);
      S_RINSE: phase_len = TIME_W'(T_RINSE);
      S_DRAIN: phase_len = TIME_W'(T_DRAIN);
      S_SPIN:  phase_len = TIME_W'(T_SPIN);
      default: phase_len = '0;
    endcase
  endfunction

  assign phase      = state;
  assign running    = (state != S_IDLE) && (state != S_DONE);
  assign div_run    = (running && !paused) || buzz_run;
  assign tick       = div_run && (div_cnt == DIV_MAX);
  assign phase_end  = running && tick && (phase_left == TIME_W'(1));
  assign start_ok   = (state == S_IDLE) && start && !door_open;
  assign rinse_goal = (prog == PROG_FULL) ? 3'(NUM_RINSE) : 3'd1;

  // in_rinse separates the first FILL/DRAIN/SPIN of the full program from the rinse rounds.
  always_comb begin
    nxt_state    = state;
    nxt_in_rinse = in_rinse;
    rinse_inc    = 1'b0;
    case (state)
      S_FILL:          nxt_state = in_rinse ? S_RINSE : S_WASH;
      S_WASH, S_RINSE: nxt_state = S_DRAIN;
      S_DRAIN:         nxt_state = S_SPIN;
      S_SPIN: begin
        if (prog == PROG_SPIN) begin
          nxt_state = S_DONE;
        end else if (!in_rinse) begin
          nxt_state    = S_FILL;
          nxt_in_rinse = 1'b1;
        end else begin
          rinse_inc = 1'b1;
          nxt_state = (({1'b0, rinse_cnt} + 4'd1) >= {1'b0, rinse_goal}) ? S_DONE : S_FILL;
        end
      end
      default: nxt_state = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      prog       <= PROG_FULL;
      in_rinse   <= 1'b0;
      div_cnt    <= '0;
      rinse_cnt  <= '0;
      phase_left <= '0;
      busy       <= 1'b0;
      paused     <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (div_run) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
      end else if (!running) begin
        div_cnt <= '0;
      end
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            prog       <= (mode == 2'd3) ? PROG_FULL : mode;
            in_rinse   <= (mode == PROG_RINSE);
            div_cnt    <= '0;
            rinse_cnt  <= '0;
            busy       <= 1'b1;
            paused     <= 1'b0;
            state      <= (mode == PROG_SPIN) ? S_DRAIN : S_FILL;
            phase_left <= (mode == PROG_SPIN) ? phase_len(S_DRAIN) : phase_len(S_FILL);
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          phase_left <= '0;
        end
        default: begin
          // An open door wins over any pause pulse, so resume needs the door closed.
          if (door_open) begin
            paused <= 1'b1;
          end else if (pause) begin
            paused <= ~paused;
          end
          if (tick) begin
            if (phase_left == TIME_W'(1)) begin
              state    <= nxt_state;
              in_rinse <= nxt_in_rinse;
              if (rinse_inc && (rinse_cnt != 3'(NUM_RINSE))) begin
                rinse_cnt <= rinse_cnt + 3'd1;
              end
              if (nxt_state == S_DONE) begin
                busy       <= 1'b0;
                paused     <= 1'b0;
                done_pulse <= 1'b1;
                phase_left <= '0;
              end else begin
                phase_left <= phase_len(nxt_state);
              end
            end else begin
              phase_left <= phase_left - TIME_W'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef WASHER_BUZZER_EN
  localparam int BUZ_W = (BUZZ_TICKS > 0) ? $clog2(BUZZ_TICKS + 1) : 1;
  logic [BUZ_W-1:0] buzz_left;

  // The divider keeps running in DONE/IDLE while the buzzer sounds.
  assign buzz_run = buzzer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzzer    <= 1'b0;
      buzz_left <= '0;
    end else if (start_ok) begin
      buzzer    <= 1'b0;
      buzz_left <= '0;
    end else if (phase_end && (nxt_state == S_DONE)) begin
      buzzer    <= 1'b1;
      buzz_left <= BUZ_W'(BUZZ_TICKS);
    end else if (buzzer && tick) begin
      buzz_left <= buzz_left - 1'b1;
      if (buzz_left == BUZ_W'(1)) begin
        buzzer <= 1'b0;
      end
    end
  end
`else
  assign buzz_run = 1'b0;
  assign buzzer   = 1'b0;
`endif

endmodule

// File: tb/tb_wash_sequencer.sv
`timescale 1ns/1ps
// Directed bench for wash_sequencer: a negedge monitor compares each finished phase length
// and the completion time against expectations queued by the stimulus.
module tb_wash_sequencer;
  localparam int W = 16;
`ifdef WASHER_BUZZER_EN
  localparam logic BUZZ_AT_DONE = 1'b1;
  localparam int   BUZZ_TAIL    = 11;
`else
  localparam logic BUZZ_AT_DONE = 1'b0;
  localparam int   BUZZ_TAIL    = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       pause;
  logic       door_open;
  logic [1:0] mode;
  logic [2:0] phase;
  logic [2:0] rinse_cnt;
  logic [7:0] phase_left;
  logic       busy;
  logic       paused;
  logic       done_pulse;
  logic       buzzer;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [2:0]  mon_phase = 3'd0;
  logic [12:0] mon_len   = 13'd0;
  logic [12:0] prog_cyc  = 13'd0;

  wash_sequencer #(
    .CLK_PER_TICK(4), .TIME_W(8), .NUM_RINSE(1), .T_FILL(2), .T_WASH(3),
    .T_RINSE(2), .T_DRAIN(2), .T_SPIN(2), .BUZZ_TICKS(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .door_open(door_open),
    .mode(mode), .phase(phase), .rinse_cnt(rinse_cnt), .phase_left(phase_left),
    .busy(busy), .paused(paused), .done_pulse(done_pulse), .buzzer(buzzer)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard
  task automatic expect_seg(input logic [2:0] p, input int len);
    exp_q.push_back({p, 13'(len)});
  endtask

  task automatic sb_check(input string tag, input logic [2:0] p, input logic [12:0] len);
    logic [W-1:0] e;
    e = 16'hFFFF;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    checks++;
    assert ({p, len} === e) else begin
      errors++;
      $error("FAIL %s observed phase=%0d len=%0d expected phase=%0d len=%0d",
             tag, p, len, e[15:13], e[12:0]);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_phase = 3'd0;
      mon_len   = 13'd0;
      prog_cyc  = 13'd0;
    end else begin
      prog_cyc = prog_cyc + 13'd1;
      if (phase !== mon_phase) begin
        if (mon_phase >= 3'd1 && mon_phase <= 3'd5) sb_check("phase_len", mon_phase, mon_len);
        if (mon_phase == 3'd0) prog_cyc = 13'd0;
        mon_phase = phase;
        mon_len   = 13'd1;
      end else begin
        mon_len = mon_len + 13'd1;
      end
      if (done_pulse) sb_check("done_at", 3'd6, prog_cyc);
    end
  end

  // Driver tasks
  task automatic start_prog(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_pause();
    pause = 1'b1;
    step();
    pause = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (done_pulse) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, seen, 1);
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] p, input logic [7:0] pl,
                            input int max_cyc);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (phase === p && phase_left === pl) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check(tag, found, 1);
  endtask

  task automatic buzz_tail_check();
    int n;
    n = 0;
    while (buzzer === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("buzz_tail", n, BUZZ_TAIL);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; door_open = 1'b0; mode = 2'd0;
    repeat (3) step();
    check("rst_phase", phase, 0);
    check("rst_rinse_cnt", rinse_cnt, 0);
    check("rst_phase_left", phase_left, 0);
    check("rst_busy", busy, 0);
    check("rst_paused", paused, 0);
    check("rst_done", done_pulse, 0);
    check("rst_buzzer", buzzer, 0);
    rst_n = 1'b1;
    step();

    // Full program, undisturbed
    expect_seg(1, 8); expect_seg(2, 12); expect_seg(4, 8); expect_seg(5, 8);
    expect_seg(1, 8); expect_seg(3, 8);  expect_seg(4, 8); expect_seg(5, 8);
    expect_seg(6, 68);
    start_prog(2'd0);
    check("t1_phase", phase, 1);
    check("t1_busy", busy, 1);
    check("t1_left", phase_left, 2);
    repeat (4) step();
    check("t1_left_dec", phase_left, 1);
    repeat (4) step();
    check("t1_wash", phase, 2);
    check("t1_wash_left", phase_left, 3);
    wait_done("t1_done_seen", 200);
    check("t1_done_phase", phase, 6);
    check("t1_rinse_cnt", rinse_cnt, 1);
    check("t1_busy_fall", busy, 0);
    check("t1_buzzer", buzzer, BUZZ_AT_DONE);
    step();
    check("t1_idle", phase, 0);
    check("t1_idle_left", phase_left, 0);
    check("t1_done_1cyc", done_pulse, 0);
    check("t1_rinse_hold", rinse_cnt, 1);
    buzz_tail_check();

    // Spin-only program
    expect_seg(4, 8); expect_seg(5, 8); expect_seg(6, 16);
    start_prog(2'd2);
    check("t2_phase", phase, 4);
    check("t2_rinse_clr", rinse_cnt, 0);
    wait_done("t2_done_seen", 60);
    check("t2_rinse_cnt", rinse_cnt, 0);
    step();

    // Start with door open is ignored; pause in IDLE does nothing
    door_open = 1'b1;
    start_prog(2'd0);
    check("t3_phase", phase, 0);
    check("t3_busy", busy, 0);
    door_open = 1'b0;
    pulse_pause();
    check("t3_idle_pause", paused, 0);
    repeat (20) step();

    // Pause for 20 cycles during WASH
    expect_seg(1, 8); expect_seg(2, 32); expect_seg(4, 8); expect_seg(5, 8);
    expect_seg(1, 8); expect_seg(3, 8);  expect_seg(4, 8); expect_seg(5, 8);
    expect_seg(6, 88);
    start_prog(2'd3);
    wait_phase("t4_reach_wash", 3'd2, 8'd2, 40);
    pulse_pause();
    check("t4_paused", paused, 1);
    repeat (19) step();
    check("t4_frozen", phase_left, 2);
    check("t4_still_paused", paused, 1);
    pulse_pause();
    check("t4_resumed", paused, 0);
    check("t4_left_after", phase_left, 2);
    wait_done("t4_done_seen", 200);
    check("t4_rinse_cnt", rinse_cnt, 1);
    step();
    buzz_tail_check();

    // Door opened during DRAIN
    expect_seg(4, 15); expect_seg(5, 8); expect_seg(6, 23);
    start_prog(2'd2);
    repeat (2) step();
    door_open = 1'b1;
    step();
    check("t5_door_hold", paused, 1);
    pulse_pause();
    check("t5_pause_door_open", paused, 1);
    door_open = 1'b0;
    repeat (5) step();
    check("t5_stays_paused", paused, 1);
    check("t5_phase", phase, 4);
    check("t5_left", phase_left, 2);
    pulse_pause();
    check("t5_resumed", paused, 0);
    wait_done("t5_done_seen", 60);
    step();
    buzz_tail_check();

    // Reset in the middle of RINSE
    expect_seg(1, 8); expect_seg(2, 12); expect_seg(4, 8); expect_seg(5, 8); expect_seg(1, 8);
    start_prog(2'd0);
    wait_phase("t6_reach_rinse", 3'd3, 8'd2, 100);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_phase", phase, 0);
    check("t6_busy", busy, 0);
    check("t6_left", phase_left, 0);
    check("t6_rinse_cnt", rinse_cnt, 0);
    check("t6_paused", paused, 0);
    check("t6_done", done_pulse, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("t6_no_done", done_pulse, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
